multiplicador_sat: RTL



---
 rtl/multiplicador_sat.sv | 131 +++++++++++++
 1 files changed

// File: rtl/multiplicador_sat.sv
// Sequential shift-add signed fixed-point multiplier with floor rounding and
// symmetric saturation, using a Start/Done handshake (one result per Width+2 clocks).
module multiplicador_sat #(
    parameter int Width     = 4,
    parameter int Signo     = 1,
    parameter int Magnitud  = 2,
    parameter int Presicion = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [Width-1:0] A,
    input  logic [Width-1:0] B,
    output logic [Width-1:0] Y,
    output logic             Done,
    output logic             Busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    localparam int PW = 2 * Width;
    localparam int CW = $clog2(Width + 1);
    localparam logic signed [PW:0] SAT_HI = (PW + 1)'((1 << (Width - 1)) - 1);
    localparam logic signed [PW:0] SAT_LO = -SAT_HI;

    generate
        if (Width != Signo + Magnitud + Presicion) begin : g_bad_format
            $error("multiplicador_sat: Width must equal Signo+Magnitud+Presicion");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [Width-1:0] mplier_q, mplier_d;
    logic             neg_q, neg_d;
    logic [Width-1:0] y_q, y_d;
    logic             done_q, done_d;

    // Magnitudes are Width-bit unsigned so -2^(Width-1) maps to 2^(Width-1) exactly.
    logic [Width-1:0] a_mag, b_mag;
    logic signed [PW:0] prod_s, r_s;

    always_comb begin
        a_mag = A[Width-1] ? (~A + Width'(1)) : A;
        b_mag = B[Width-1] ? (~B + Width'(1)) : B;
    end

    always_comb begin
        prod_s = neg_q ? -$signed({1'b0, acc_q}) : $signed({1'b0, acc_q});
        r_s    = prod_s >>> Presicion;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        y_d      = y_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    acc_d    = '0;
                    mcand_d  = {{Width{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    neg_d    = A[Width-1] ^ B[Width-1];
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(Width - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                if (r_s > SAT_HI) begin
                    y_d = SAT_HI[Width-1:0];
                end else if (r_s < SAT_LO) begin
                    y_d = SAT_LO[Width-1:0];
                end else begin
                    y_d = r_s[Width-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            y_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            y_q      <= y_d;
            done_q   <= done_d;
        end
    end

    assign Y    = y_q;
    assign Done = done_q;
    assign Busy = (state_q != IDLE);

endmodule
